// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-set controller.
//   - SEC / MIN / HOUR : one-hot field codes used on buttons, commands and o_hms
//   - state_e          : FSM state encoding for the button auto-repeat path
//   - is_onehot3       : helper used to qualify button and command vectors
package watch_pkg;

    localparam logic [2:0] SEC  = 3'b001;
    localparam logic [2:0] MIN  = 3'b010;
    localparam logic [2:0] HOUR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == SEC) || (v == MIN) || (v == HOUR);
    endfunction

endpackage

// File: rtl/watch_set_ctrl_if.sv
// Signal bundle between the watch time-set controller and its environment.
//   set_en                     : time-set mode enable (level)
//   btn_sec/btn_min/btn_hour   : debounced button levels
//   cmd_inc[2:0]               : single-cycle UART increment strobe, one-hot {hour,min,sec}
//   o_hms[2:0]                 : registered increment pulse to the watch datapath
//   o_busy                     : button path active (FSM not idle)
//   o_drop                     : one-cycle pulse when a command is discarded
// master = environment side, slave = controller side.
interface watch_set_ctrl_if;

    logic       set_en;
    logic       btn_sec;
    logic       btn_min;
    logic       btn_hour;
    logic [2:0] cmd_inc;
    logic [2:0] o_hms;
    logic       o_busy;
    logic       o_drop;

    modport master (
        output set_en, btn_sec, btn_min, btn_hour, cmd_inc,
        input  o_hms, o_busy, o_drop
    );

    modport slave (
        input  set_en, btn_sec, btn_min, btn_hour, cmd_inc,
        output o_hms, o_busy, o_drop
    );

endinterface

// File: rtl/watch_hold_timer.sv
// Up-counting interval timer for the hold / auto-repeat delays.
//   clk, reset  : clock, synchronous active-high reset
//   clear_i     : force count to 0 (priority over enable)
//   enable_i    : advance count by one
//   tc_i        : terminal count (interval length minus one)
//   done_o      : count has reached tc_i
module watch_hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] tc_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)       cnt_d = '0;
        else if (enable_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch time-set controller: turns held buttons into an initial increment
// pulse plus auto-repeat, and merges single-cycle UART increment commands
// through a one-slot pending register. Button pulses win; a command that
// collides with a button pulse waits one slot.
//   clk, reset : clock, synchronous active-high reset
//   bus        : watch_set_ctrl_if.slave (buttons, commands, o_hms/o_busy/o_drop)
//
// state     | meaning
// ST_IDLE   | waiting for a single button press
// ST_HOLD   | first pulse issued, timing the hold delay
// ST_REPEAT | auto-repeating every REPEAT_CYCLES
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    watch_set_ctrl_if.slave   bus
);

    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
    localparam logic [TW-1:0] HOLD_TC = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_TC  = TW'(REPEAT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] field_q, field_d;
    logic [2:0] pend_q, pend_d;
    logic [2:0] hms_q, hms_d;
    logic       drop_q, drop_d;

    logic [2:0]    btn_vec;
    logic          btn_held;
    logic          btn_pulse;
    logic [2:0]    pulse_field;
    logic          cmd_ok;
    logic          tmr_clear;
    logic          tmr_en;
    logic          tmr_done;
    logic [TW-1:0] tmr_tc;

    assign btn_vec  = {bus.btn_hour, bus.btn_min, bus.btn_sec};
    assign btn_held = |(btn_vec & field_q);
    assign cmd_ok   = bus.set_en && is_onehot3(bus.cmd_inc);

    watch_hold_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (tmr_clear),
        .enable_i (tmr_en),
        .tc_i     (tmr_tc),
        .done_o   (tmr_done)
    );

    // Button path FSM
    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        btn_pulse   = 1'b0;
        pulse_field = field_q;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;
        tmr_tc      = (state_q == ST_REPEAT) ? REP_TC : HOLD_TC;
        case (state_q)
            ST_IDLE: begin
                if (bus.set_en && is_onehot3(btn_vec)) begin
                    field_d     = btn_vec;
                    pulse_field = btn_vec;
                    btn_pulse   = 1'b1;
                    tmr_clear   = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!bus.set_en || !btn_held) begin
                    field_d   = 3'b000;
                    tmr_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tmr_done) begin
                    btn_pulse = 1'b1;
                    tmr_clear = 1'b1;
                    state_d   = ST_REPEAT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                field_d   = 3'b000;
                tmr_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Output merge and pending slot. The slot drains on any edge without a
    // button pulse; a new command may refill it on that same edge.
    always_comb begin
        hms_d  = 3'b000;
        pend_d = pend_q;
        drop_d = 1'b0;
        if (!bus.set_en) begin
            pend_d = 3'b000;
        end else if (btn_pulse) begin
            hms_d = pulse_field;
            if (cmd_ok) begin
                if (pend_q == 3'b000) pend_d = bus.cmd_inc;
                else                  drop_d = 1'b1;
            end
        end else if (pend_q != 3'b000) begin
            hms_d  = pend_q;
            pend_d = cmd_ok ? bus.cmd_inc : 3'b000;
        end else if (cmd_ok) begin
            hms_d = bus.cmd_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            field_q <= 3'b000;
            pend_q  <= 3'b000;
            hms_q   <= 3'b000;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            pend_q  <= pend_d;
            hms_q   <= hms_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.o_hms  = hms_q;
    assign bus.o_busy = (state_q != ST_IDLE);
    assign bus.o_drop = drop_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed self-checking bench for watch_set_ctrl.
// dut_a uses HOLD_CYCLES=10 / REPEAT_CYCLES=4; dut_b uses 2 / 1 so that
// button pulses land on consecutive edges, which is the only way to fill
// the pending slot twice in a row and exercise the drop path.
module tb_watch_set_ctrl;
    import watch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    watch_set_ctrl_if bus_a ();
    watch_set_ctrl_if bus_b ();

    watch_set_ctrl #(.HOLD_CYCLES(10), .REPEAT_CYCLES(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    watch_set_ctrl #(.HOLD_CYCLES(2), .REPEAT_CYCLES(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] hms, input logic busy, input logic drop);
        check_eq({tag, "_hms"},  32'(bus_a.o_hms),  32'(hms));
        check_eq({tag, "_busy"}, 32'(bus_a.o_busy), 32'(busy));
        check_eq({tag, "_drop"}, 32'(bus_a.o_drop), 32'(drop));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_hms;

        reset = 1'b1;
        bus_a.set_en = 1'b0; bus_a.btn_sec = 1'b0; bus_a.btn_min = 1'b0; bus_a.btn_hour = 1'b0;
        bus_a.cmd_inc = 3'b000;
        bus_b.set_en = 1'b0; bus_b.btn_sec = 1'b0; bus_b.btn_min = 1'b0; bus_b.btn_hour = 1'b0;
        bus_b.cmd_inc = 3'b000;

        // Reset for two cycles
        tick; tick;
        check_outs("reset", 3'b000, 1'b0, 1'b0);
        check_eq("reset_b_hms", 32'(bus_b.o_hms), 32'h0);
        reset = 1'b0;

        // Held minute button: pulses at 0, 10, 14, 18
        bus_a.set_en  = 1'b1;
        bus_a.btn_min = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick;
            exp_hms = (k == 0 || k == 10 || k == 14 || k == 18) ? MIN : 3'b000;
            check_eq($sformatf("min_hold_e%0d", k), 32'(bus_a.o_hms), 32'(exp_hms));
        end
        check_eq("min_hold_busy", 32'(bus_a.o_busy), 32'h1);
        bus_a.btn_min = 1'b0;
        tick;
        check_outs("min_release", 3'b000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick;
            check_eq($sformatf("min_quiet_%0d", k), 32'(bus_a.o_hms), 32'h0);
        end

        // Two buttons at once: ignored
        bus_a.btn_sec  = 1'b1;
        bus_a.btn_hour = 1'b1;
        tick;
        check_outs("two_btn", 3'b000, 1'b0, 1'b0);
        bus_a.btn_sec  = 1'b0;
        bus_a.btn_hour = 1'b0;
        tick;

        // Button press and command on the same edge: command slips one cycle
        bus_a.btn_sec = 1'b1;
        bus_a.cmd_inc = HOUR;
        tick;
        check_outs("coinc_btn", SEC, 1'b1, 1'b0);
        bus_a.cmd_inc = 3'b000;
        tick;
        check_outs("coinc_cmd", HOUR, 1'b1, 1'b0);
        bus_a.btn_sec = 1'b0;
        tick;
        check_outs("coinc_release", 3'b000, 1'b0, 1'b0);

        // Command qualification
        bus_a.cmd_inc = 3'b011;
        tick;
        check_outs("cmd_not_onehot", 3'b000, 1'b0, 1'b0);
        bus_a.cmd_inc = MIN;
        tick;
        check_outs("cmd_direct", MIN, 1'b0, 1'b0);
        bus_a.set_en  = 1'b0;
        bus_a.cmd_inc = SEC;
        tick;
        check_outs("cmd_set_en_low", 3'b000, 1'b0, 1'b0);
        bus_a.cmd_inc = 3'b000;
        bus_a.set_en  = 1'b1;
        tick;

        // set_en drops mid-REPEAT with a command pending
        bus_a.btn_hour = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k == 14) bus_a.cmd_inc = SEC;
            tick;
            exp_hms = (k == 0 || k == 10 || k == 14) ? HOUR : 3'b000;
            check_eq($sformatf("hour_hold_e%0d", k), 32'(bus_a.o_hms), 32'(exp_hms));
        end
        bus_a.cmd_inc  = 3'b000;
        bus_a.set_en   = 1'b0;
        bus_a.btn_hour = 1'b0;
        tick;
        check_outs("set_en_drop", 3'b000, 1'b0, 1'b0);
        bus_a.set_en = 1'b1;
        tick;
        check_outs("pend_cleared", 3'b000, 1'b0, 1'b0);

        // Reset mid-HOLD
        bus_a.btn_sec = 1'b1;
        tick;
        check_outs("pre_reset_press", SEC, 1'b1, 1'b0);
        tick; tick;
        check_eq("pre_reset_busy", 32'(bus_a.o_busy), 32'h1);
        reset = 1'b1;
        bus_a.btn_sec = 1'b0;
        tick;
        check_outs("reset_mid_hold", 3'b000, 1'b0, 1'b0);
        reset = 1'b0;
        tick;
        check_outs("after_reset", 3'b000, 1'b0, 1'b0);

        // dut_b: consecutive repeat pulses, second command dropped
        bus_b.set_en   = 1'b1;
        bus_b.btn_hour = 1'b1;
        tick;
        check_eq("b_e0_hms", 32'(bus_b.o_hms), 32'(HOUR));
        tick;
        check_eq("b_e1_hms", 32'(bus_b.o_hms), 32'h0);
        tick;
        check_eq("b_e2_hms", 32'(bus_b.o_hms), 32'(HOUR));
        bus_b.cmd_inc = MIN;
        tick;
        check_eq("b_e3_hms",  32'(bus_b.o_hms),  32'(HOUR));
        check_eq("b_e3_drop", 32'(bus_b.o_drop), 32'h0);
        bus_b.cmd_inc = SEC;
        tick;
        check_eq("b_e4_hms",  32'(bus_b.o_hms),  32'(HOUR));
        check_eq("b_e4_drop", 32'(bus_b.o_drop), 32'h1);
        bus_b.cmd_inc  = 3'b000;
        bus_b.btn_hour = 1'b0;
        tick;
        check_eq("b_e5_hms",  32'(bus_b.o_hms),  32'(MIN));
        check_eq("b_e5_drop", 32'(bus_b.o_drop), 32'h0);
        check_eq("b_e5_busy", 32'(bus_b.o_busy), 32'h0);
        tick;
        check_eq("b_e6_hms", 32'(bus_b.o_hms), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
